// File: rtl/full_adder_4bit.sv
// Registered ripple-carry adder of two WIDTH-bit operands plus carry-in, with zero/overflow flags.
// Latency: one clk from an en=1 edge to s/cout/zero/ovf with a one-cycle valid pulse.
// Backpressure: none; a new operand set is accepted on every en=1 edge.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module full_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             valid,
    output logic             zero,
    output logic             ovf
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Result registers only load on en, so idle-cycle input activity (including X) never reaches the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s     <= '0;
            cout  <= 1'b0;
            zero  <= 1'b1;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                s    <= sum;
                cout <= carry[WIDTH];
                zero <= (sum == '0);
                ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_full_adder_4bit.sv
// Scoreboarded random and directed test of full_adder_4bit against an arithmetic reference model.
module tb_full_adder_4bit;
    typedef struct packed {
        logic [3:0] s;
        logic       cout;
        logic       zero;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       valid;
    logic       zero;
    logic       ovf;

    exp_t exp_q[$];
    exp_t last_e;
    int   errors = 0;
    int   checks = 0;

    full_adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .valid (valid),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        exp_t m;
        int   u;
        int   sg;
        u      = int'(ta) + int'(tb) + int'(tc);
        sg     = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
        m.s    = u[3:0];
        m.cout = (u >= 16);
        m.zero = ((u % 16) == 0);
        m.ovf  = (sg > 7) || (sg < -8);
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_outs(input string name, input exp_t e, input logic v);
        check({name, ".s"}, 32'(s), 32'(e.s));
        check({name, ".cout"}, 32'(cout), 32'(e.cout));
        check({name, ".zero"}, 32'(zero), 32'(e.zero));
        check({name, ".ovf"}, 32'(ovf), 32'(e.ovf));
        check({name, ".valid"}, 32'(valid), 32'(v));
    endtask

    task automatic cap(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        @(negedge clk);
        a   = ta;
        b   = tb;
        cin = tc;
        en  = 1'b1;
        last_e = model(ta, tb, tc);
        exp_q.push_back(last_e);
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
    endtask

    // Monitor: every valid result is matched against the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result.s", 32'(s), 32'(e.s));
                    check("result.cout", 32'(cout), 32'(e.cout));
                    check("result.zero", 32'(zero), 32'(e.zero));
                    check("result.ovf", 32'(ovf), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        exp_t rst_e;
        logic [3:0] da [8] = '{4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b0100, 4'b1110, 4'b0111, 4'b1111};
        logic [3:0] db [8] = '{4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b0010, 4'b1010, 4'b0001, 4'b0000};
        logic       dc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        rst_e = '{s: 4'b0000, cout: 1'b0, zero: 1'b1, ovf: 1'b0};

        reset = 1'b1;
        en    = 1'b0;
        a     = 4'b0;
        b     = 4'b0;
        cin   = 1'b0;
        #2;
        check_outs("reset_async", rst_e, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outs("after_reset_idle", rst_e, 1'b0);

        for (int i = 0; i < 8; i++) cap(da[i], db[i], dc[i]);

        // Hold with en low while operands churn; last captured result must persist.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            en  = 1'b0;
            a   = (k == 2) ? 4'bxxxx : 4'($urandom);
            b   = 4'($urandom);
            cin = (k == 2) ? 1'bx : 1'b0;
            @(posedge clk);
            #1;
            check_outs("hold_en0", last_e, 1'b0);
        end

        cap(4'b0111, 4'b0001, 1'b0);
        idle();
        #1;
        check("pre_reset.s", 32'(s), 32'd8);
        reset = 1'b1;
        #1;
        check_outs("midstream_reset", rst_e, 1'b0);

        // Capture attempt while reset is held must be ignored.
        a   = 4'd5;
        b   = 4'd5;
        cin = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        #1;
        check_outs("reset_wins", rst_e, 1'b0);
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_reset_release", rst_e, 1'b0);

        for (int i = 0; i < 512; i++) cap(i[3:0], i[7:4], i[8]);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3, 0) != 0) cap(4'($urandom), 4'($urandom), 1'($urandom));
            else idle();
        end

        idle();
        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/full_adder_4bit.md
FULL_ADDER_4BIT -- requirements
Module: full_adder_4bit

Interface
REQ-001 Parameter WIDTH, default 4: operand width; this block is built and verified only at WIDTH=4.
REQ-002 Port clk  input  1  rising-edge clock; the block uses a single clock.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port en  input  1  capture strobe; operands are sampled on a rising clk edge when en=1.
REQ-005 Port a  input  4  operand A, unsigned, a[0] is the LSB.
REQ-006 Port b  input  4  operand B, unsigned, b[0] is the LSB.
REQ-007 Port cin  input  1  carry into bit 0.
REQ-008 Port s  output  4  registered sum bits.
REQ-009 Port cout  output  1  registered carry out of bit 3.
REQ-010 Port valid  output  1  high for one cycle when s/cout hold a newly captured result.
REQ-011 Port zero  output  1  registered flag, 1 when the captured s is 4'b0000, regardless of cout.
REQ-012 Port ovf  output  1  registered two's-complement overflow flag: carry into bit 3 XOR carry out of bit 3.

Function
REQ-013 The sum SHALL be formed as a 4-stage ripple chain of 1-bit full-adder cells.
REQ-014 Each cell SHALL compute s_i = a_i^b_i^c_i and c_(i+1) = a_i&b_i | c_i&(a_i^b_i), with c_0 = cin and cout = c_4.
REQ-015 {cout,s} SHALL equal a + b + cin exactly, covering the range 0..31 with no saturation.
REQ-016 On a rising clk edge with en=1 and reset=0, s, cout, zero and ovf SHALL load the values computed from the current a, b and cin, and valid SHALL be set to 1.
REQ-017 On a rising clk edge with en=0 and reset=0, s, cout, zero and ovf SHALL hold their values, and valid SHALL be 0.
REQ-018 Latency SHALL be exactly one clock: inputs sampled at edge N appear on the outputs after edge N.
REQ-019 With en held at 1, the block SHALL accept a new operand set every cycle (throughput 1/clk), and valid SHALL stay at 1.
REQ-020 Input changes between clock edges SHALL NOT affect any output.
REQ-021 No output SHALL have a combinational path from any input.
REQ-022 X/Z on a, b or cin while en=0 SHALL NOT propagate to the outputs.

Reset
REQ-023 While reset=1, s=4'b0000, cout=0, zero=1, ovf=0 and valid=0, applied immediately without waiting for a clk edge.
REQ-024 If reset and an en=1 clock edge coincide, reset SHALL win and no result is captured.
REQ-025 Asserting reset mid-stream SHALL discard the pending result.
REQ-026 After reset deasserts, the first en=1 edge SHALL produce the first valid result.

Verification
REQ-027 Apply reset, then release it with en=0 -> s=0000, cout=0, zero=1, ovf=0, valid=0.
REQ-028 Capture the following operand sets with en=1:
- a=0000, b=0000, cin=0 -> s=0000, cout=0, zero=1, valid=1.
- a=0000, b=0000, cin=1 -> s=0001, cout=0, zero=0.
- a=0110, b=1100, cin=0 -> s=0010, cout=1, ovf=0.
- a=0110, b=1100, cin=1 -> s=0011, cout=1.
- a=0100, b=0010, cin=0 -> s=0110, cout=0.
- a=1110, b=1010, cin=0 -> s=1000, cout=1, ovf=0.
REQ-029 Drive a=0111, b=0001, cin=0 -> s=1000, cout=0, ovf=1; then a=1111, b=0000, cin=1 -> s=0000, cout=1, zero=1.
REQ-030 Hold en=0 for 3 cycles while toggling a and b -> outputs unchanged, valid=0.
REQ-031 Assert reset asynchronously between edges after a result s=1000 -> s=0000 and valid=0 immediately.
REQ-032 Run an exhaustive sweep of all 512 {a,b,cin} combinations back-to-back with en=1 -> each {cout,s} equals a+b+cin one cycle later.
